// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux_rr_arbiter
// Purpose  : Round-robin arbiter that shares one 4:1 multiplexer between four
//            requesters. Requester i owns mux input in<i>. The arbiter drives
//            the mux select lines (address1:address0) and one-hot grants.
//            A grant is held until its requester releases, or until the
//            hold-timeout forces rotation while another requester waits.
//
// Ports    : clk                 rising-edge clock
//            reset               synchronous, active-high reset
//            req0..req3          level requests, held while the mux is wanted
//            gnt0..gnt3          registered one-hot grants
//            address0/address1   registered mux select LSB / MSB
//            sel_valid           registered, high while some grant is active
//            hold_cnt            registered, cycles the current grant is held
//            lock                (only with MUX_ARB_LOCK_EN) suppresses
//                                timeout preemption for the current owner
//
// Params   : MAX_HOLD  grant cycles before forced rotation (0 = unlimited)
//            HOLD_W    hold counter width, 2**HOLD_W must exceed MAX_HOLD
//
// Options  : `define MUX_ARB_LOCK_EN adds the lock input.
//
// Revision : 1.0  initial release
// ============================================================================
module mux_rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              req2,
    input  logic              req3,
    output logic              gnt0,
    output logic              gnt1,
    output logic              gnt2,
    output logic              gnt3,
    output logic              address0,
    output logic              address1,
    output logic              sel_valid,
    output logic [HOLD_W-1:0] hold_cnt
`ifdef MUX_ARB_LOCK_EN
    ,
    input  logic              lock
`endif
);

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_GRANT = 1'b1;

    // Value at which hold_cnt stops counting. With MAX_HOLD=0 there is no
    // timeout, so the counter simply runs up to all-ones and stays there.
    localparam logic [HOLD_W-1:0] c_HOLD_SAT =
        (MAX_HOLD == 0) ? {HOLD_W{1'b1}} : HOLD_W'(MAX_HOLD - 1);

    logic [0:0]        r_state, w_state_nxt;
    logic [3:0]        r_gnt, w_gnt_nxt;
    logic [1:0]        r_addr, w_addr_nxt;
    logic              r_valid, w_valid_nxt;
    logic [HOLD_W-1:0] r_hold, w_hold_nxt;
    logic [1:0]        r_last, w_last_nxt;

    logic [3:0] w_req;
    logic [3:0] w_others;
    logic       w_owner_req;
    logic       w_lock;
    logic       w_timeout;
    logic [1:0] w_pick;
    logic       w_pick_ok;

`ifdef MUX_ARB_LOCK_EN
    assign w_lock = lock;
`else
    assign w_lock = 1'b0;
`endif

    assign w_req       = {req3, req2, req1, req0};
    // Requests excluding the current owner. In IDLE r_gnt is zero so this is
    // all requests; after a release the owner's req is already low, so the
    // same mask serves the idle, release and timeout cases alike.
    assign w_others    = w_req & ~r_gnt;
    assign w_owner_req = |(w_req & r_gnt);
    assign w_timeout   = (MAX_HOLD != 0) && (r_hold == c_HOLD_SAT) &&
                         w_owner_req && (|w_others) && !w_lock;

    // Round-robin search starting just after the last granted index.
    always_comb begin
        logic [1:0] v_idx;
        w_pick    = 2'd0;
        w_pick_ok = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            v_idx = r_last + 2'(i);
            if (!w_pick_ok && w_others[v_idx]) begin
                w_pick    = v_idx;
                w_pick_ok = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_addr_nxt  = r_addr;
        w_valid_nxt = r_valid;
        w_hold_nxt  = r_hold;
        w_last_nxt  = r_last;

        case (r_state)
            c_ST_IDLE: begin
                if (w_pick_ok) begin
                    w_state_nxt = c_ST_GRANT;
                    w_gnt_nxt   = 4'b0001 << w_pick;
                    w_addr_nxt  = w_pick;
                    w_valid_nxt = 1'b1;
                    w_hold_nxt  = '0;
                    w_last_nxt  = w_pick;
                end
            end
            c_ST_GRANT: begin
                if (!w_owner_req || w_timeout) begin
                    if (w_pick_ok) begin
                        // Back-to-back hand-over, no idle cycle in between.
                        w_gnt_nxt   = 4'b0001 << w_pick;
                        w_addr_nxt  = w_pick;
                        w_hold_nxt  = '0;
                        w_last_nxt  = w_pick;
                    end else begin
                        // Address keeps its last value so the mux select
                        // never glitches; sel_valid=0 marks it don't-care.
                        w_state_nxt = c_ST_IDLE;
                        w_gnt_nxt   = 4'b0000;
                        w_valid_nxt = 1'b0;
                        w_hold_nxt  = '0;
                    end
                end else if (r_hold != c_HOLD_SAT) begin
                    w_hold_nxt = r_hold + 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_gnt_nxt   = 4'b0000;
                w_valid_nxt = 1'b0;
                w_hold_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_gnt   <= 4'b0000;
            r_addr  <= 2'b00;
            r_valid <= 1'b0;
            r_hold  <= '0;
            r_last  <= 2'd3;  // req0 gets top priority after reset
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_addr  <= w_addr_nxt;
            r_valid <= w_valid_nxt;
            r_hold  <= w_hold_nxt;
            r_last  <= w_last_nxt;
        end
    end

    assign gnt0      = r_gnt[0];
    assign gnt1      = r_gnt[1];
    assign gnt2      = r_gnt[2];
    assign gnt3      = r_gnt[3];
    assign address0  = r_addr[0];
    assign address1  = r_addr[1];
    assign sel_valid = r_valid;
    assign hold_cnt  = r_hold;

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_rr_arbiter
// Purpose  : Self-checking bench for mux_rr_arbiter. Instance u_dut uses
//            MAX_HOLD=4, instance u_rr uses MAX_HOLD=0 (no timeout).
//            Expected outputs are hand-derived vectors queued when stimulus
//            is driven and compared after the following rising edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_mux_rr_arbiter;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] addr;
        logic       valid;
        logic [3:0] hold;
        logic       chk_hold;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req_a = 4'b0000;
    logic [3:0] req_b = 4'b0000;
`ifdef MUX_ARB_LOCK_EN
    logic       lock = 1'b0;
`endif

    logic [3:0] gnt_a, gnt_b;
    logic [1:0] addr_a, addr_b;
    logic       valid_a, valid_b;
    logic [3:0] hold_a, hold_b;

    int n_cmp = 0;
    int n_err = 0;

    vec_t tbl[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    mux_rr_arbiter #(.MAX_HOLD(4), .HOLD_W(4)) u_dut (
        .clk(clk), .reset(reset),
        .req0(req_a[0]), .req1(req_a[1]), .req2(req_a[2]), .req3(req_a[3]),
        .gnt0(gnt_a[0]), .gnt1(gnt_a[1]), .gnt2(gnt_a[2]), .gnt3(gnt_a[3]),
        .address0(addr_a[0]), .address1(addr_a[1]),
        .sel_valid(valid_a), .hold_cnt(hold_a)
`ifdef MUX_ARB_LOCK_EN
        , .lock(lock)
`endif
    );

    mux_rr_arbiter #(.MAX_HOLD(0), .HOLD_W(4)) u_rr (
        .clk(clk), .reset(reset),
        .req0(req_b[0]), .req1(req_b[1]), .req2(req_b[2]), .req3(req_b[3]),
        .gnt0(gnt_b[0]), .gnt1(gnt_b[1]), .gnt2(gnt_b[2]), .gnt3(gnt_b[3]),
        .address0(addr_b[0]), .address1(addr_b[1]),
        .sel_valid(valid_b), .hold_cnt(hold_b)
`ifdef MUX_ARB_LOCK_EN
        , .lock(1'b0)
`endif
    );

    function automatic vec_t mk(input logic rst, input logic [3:0] req,
                                input logic [3:0] gnt, input logic [1:0] addr,
                                input logic valid, input logic [3:0] hold,
                                input logic chk_hold);
        vec_t v;
        v.rst = rst; v.req = req; v.gnt = gnt; v.addr = addr;
        v.valid = valid; v.hold = hold; v.chk_hold = chk_hold;
        return v;
    endfunction

    task automatic check(input int which, input string name);
        vec_t e;
        logic [3:0] g; logic [1:0] a; logic vl; logic [3:0] h;
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL %s: scoreboard empty, no expected value", name);
            return;
        end
        e = sb.pop_front();
        if (which == 0) begin g = gnt_a; a = addr_a; vl = valid_a; h = hold_a; end
        else            begin g = gnt_b; a = addr_b; vl = valid_b; h = hold_b; end
        if (g !== e.gnt || a !== e.addr || vl !== e.valid ||
            (e.chk_hold && h !== e.hold)) begin
            n_err++;
            $display("FAIL %s: got gnt=%b addr=%b valid=%b hold=%0d, expected gnt=%b addr=%b valid=%b hold=%0d%s",
                     name, g, a, vl, h, e.gnt, e.addr, e.valid, e.hold,
                     e.chk_hold ? "" : "(unchecked)");
        end
    endtask

    task automatic step(input int which, input vec_t v, input string name);
        @(negedge clk);
        reset = v.rst;
        if (which == 0) req_a = v.req;
        else            req_b = v.req;
        sb.push_back(v);
        @(posedge clk);
        #1;
        check(which, name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] oh_o, oh_n;
        int o, n;

        // ---- table for u_dut (MAX_HOLD=4) ----
        // reset with all requests high, then first grant to req0
        tbl.push_back(mk(1, 4'b1111, 4'b0000, 2'd0, 0, 0, 1));
        tbl.push_back(mk(1, 4'b1111, 4'b0000, 2'd0, 0, 0, 1));
        tbl.push_back(mk(0, 4'b1111, 4'b0001, 2'd0, 1, 0, 1));
        tbl.push_back(mk(0, 4'b1111, 4'b0001, 2'd0, 1, 1, 1));
        tbl.push_back(mk(0, 4'b1111, 4'b0001, 2'd0, 1, 2, 1));
        tbl.push_back(mk(0, 4'b1111, 4'b0001, 2'd0, 1, 3, 1));
        // timeout rotates to req1
        tbl.push_back(mk(0, 4'b1111, 4'b0010, 2'd1, 1, 0, 1));
        // req1 releases -> req2 back-to-back
        tbl.push_back(mk(0, 4'b1101, 4'b0100, 2'd2, 1, 0, 1));
        // req2 releases, only req0 left
        tbl.push_back(mk(0, 4'b0001, 4'b0001, 2'd0, 1, 0, 1));
        tbl.push_back(mk(0, 4'b0001, 4'b0001, 2'd0, 1, 1, 1));
        tbl.push_back(mk(0, 4'b0001, 4'b0001, 2'd0, 1, 2, 1));
        tbl.push_back(mk(0, 4'b0001, 4'b0001, 2'd0, 1, 3, 1));
        tbl.push_back(mk(0, 4'b0001, 4'b0001, 2'd0, 1, 3, 1));
        tbl.push_back(mk(0, 4'b0001, 4'b0001, 2'd0, 1, 3, 1));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 2'd0, 0, 0, 0));
        // lone holder req3: hold saturates at 3
        tbl.push_back(mk(0, 4'b1000, 4'b1000, 2'd3, 1, 0, 1));
        tbl.push_back(mk(0, 4'b1000, 4'b1000, 2'd3, 1, 1, 1));
        tbl.push_back(mk(0, 4'b1000, 4'b1000, 2'd3, 1, 2, 1));
        tbl.push_back(mk(0, 4'b1000, 4'b1000, 2'd3, 1, 3, 1));
        tbl.push_back(mk(0, 4'b1000, 4'b1000, 2'd3, 1, 3, 1));
        tbl.push_back(mk(0, 4'b1000, 4'b1000, 2'd3, 1, 3, 1));
        // release: idle, address stays 11
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 2'd3, 0, 0, 0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 2'd3, 0, 0, 0));
        // req0 and req2 alternate on timeout
        tbl.push_back(mk(0, 4'b0101, 4'b0001, 2'd0, 1, 0, 1));
        tbl.push_back(mk(0, 4'b0101, 4'b0001, 2'd0, 1, 1, 1));
        tbl.push_back(mk(0, 4'b0101, 4'b0001, 2'd0, 1, 2, 1));
        tbl.push_back(mk(0, 4'b0101, 4'b0001, 2'd0, 1, 3, 1));
        tbl.push_back(mk(0, 4'b0101, 4'b0100, 2'd2, 1, 0, 1));
        tbl.push_back(mk(0, 4'b0101, 4'b0100, 2'd2, 1, 1, 1));
        tbl.push_back(mk(0, 4'b0101, 4'b0100, 2'd2, 1, 2, 1));
        tbl.push_back(mk(0, 4'b0101, 4'b0100, 2'd2, 1, 3, 1));
        tbl.push_back(mk(0, 4'b0101, 4'b0001, 2'd0, 1, 0, 1));
        // gnt1 up to hold 2, then reset mid-grant
        tbl.push_back(mk(0, 4'b0010, 4'b0010, 2'd1, 1, 0, 1));
        tbl.push_back(mk(0, 4'b0010, 4'b0010, 2'd1, 1, 1, 1));
        tbl.push_back(mk(0, 4'b0010, 4'b0010, 2'd1, 1, 2, 1));
        tbl.push_back(mk(1, 4'b0011, 4'b0000, 2'd0, 0, 0, 1));
        // pointer back to 3: req0 beats req1
        tbl.push_back(mk(0, 4'b0011, 4'b0001, 2'd0, 1, 0, 1));

        for (int i = 0; i < tbl.size(); i++)
            step(0, tbl[i], $sformatf("vec%0d", i));

`ifdef MUX_ARB_LOCK_EN
        // lock keeps req0 past the timeout while req1 waits
        lock = 1'b1;
        step(0, mk(0, 4'b0011, 4'b0001, 2'd0, 1, 1, 1), "lock_h1");
        step(0, mk(0, 4'b0011, 4'b0001, 2'd0, 1, 2, 1), "lock_h2");
        step(0, mk(0, 4'b0011, 4'b0001, 2'd0, 1, 3, 1), "lock_h3");
        step(0, mk(0, 4'b0011, 4'b0001, 2'd0, 1, 3, 1), "lock_sat1");
        step(0, mk(0, 4'b0011, 4'b0001, 2'd0, 1, 3, 1), "lock_sat2");
        lock = 1'b0;
        step(0, mk(0, 4'b0011, 4'b0010, 2'd1, 1, 0, 1), "unlock_rot");
        // release still works with lock high
        lock = 1'b1;
        step(0, mk(0, 4'b0001, 4'b0001, 2'd0, 1, 0, 1), "lock_release");
        lock = 1'b0;
`endif

        // ---- u_rr (MAX_HOLD=0): strict round-robin by release ----
        step(1, mk(0, 4'b1111, 4'b0001, 2'd0, 1, 0, 1), "rr_first");
        for (int k = 0; k < 4; k++) begin
            o = k % 4;
            n = (k + 1) % 4;
            oh_o = 4'b0001 << o;
            oh_n = 4'b0001 << n;
            step(1, mk(0, 4'b1111, oh_o, 2'(o), 1, 1, 1), $sformatf("rr%0d_h1", k));
            step(1, mk(0, 4'b1111, oh_o, 2'(o), 1, 2, 1), $sformatf("rr%0d_h2", k));
            step(1, mk(0, 4'b1111 & ~oh_o, oh_n, 2'(n), 1, 0, 1), $sformatf("rr%0d_next", k));
        end
        // no timeout: after re-raise owner 0 keeps counting well past 4
        for (int k = 1; k <= 6; k++)
            step(1, mk(0, 4'b1111, 4'b0001, 2'd0, 1, 4'(k), 1), $sformatf("rr_nolimit%0d", k));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
